// File: rtl/sblk_act_feeder.sv
// Streaming activation feeder: turns batch requests from the sub-block controller
// into n_tp*n_tn*N_TILE registered activation beats pulled from a valid/ready source.
module sblk_act_feeder #(
  parameter int unsigned N_TILE      = 4,
  parameter int unsigned WID_ACT     = 8,
  parameter int unsigned WID_INST_TN = 3,
  parameter int unsigned WID_INST_TP = 2,
  parameter int unsigned MAX_PEND    = 2
) (
  input  logic                     clk_l,
  input  logic                     rst_n,
  input  logic                     cfg_en,
  input  logic [WID_INST_TN-1:0]   cfg_n_tn,
  input  logic [WID_INST_TP-1:0]   cfg_n_tp,
  input  logic                     act_in_req,
  input  logic [2*WID_ACT-1:0]     src_data,
  input  logic                     src_vld,
  output logic                     src_rdy,
  output logic [2*WID_ACT-1:0]     act_in,
  output logic                     act_in_vld,
  output logic                     batch_done,
  output logic                     busy,
  output logic                     err_ovf
);

  localparam int unsigned WID_LEN  = WID_INST_TN + WID_INST_TP + $clog2(N_TILE);
  localparam int unsigned WID_PEND = $clog2(MAX_PEND + 1);
  localparam int unsigned WID_DAT  = 2 * WID_ACT;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [0:0]          r_state;
  logic [WID_PEND-1:0] r_pend;
  logic [WID_LEN-1:0]  r_cnt;
  logic [WID_LEN-1:0]  r_len;
  logic [WID_DAT-1:0]  r_act_in;
  logic                r_act_in_vld;
  logic                r_batch_done;
  logic                r_busy;
  logic                r_err_ovf;
  logic                r_src_rdy;

  logic [0:0]          w_state_nxt;
  logic [WID_PEND-1:0] w_pend_nxt;
  logic [WID_LEN-1:0]  w_cnt_nxt;
  logic [WID_LEN-1:0]  w_len_nxt;
  logic [WID_DAT-1:0]  w_act_nxt;
  logic                w_vld_nxt;
  logic                w_done_nxt;
  logic                w_busy_nxt;
  logic                w_err_nxt;
  logic                w_rdy_nxt;

  logic                w_beat;
  logic                w_last;
  logic                w_done;

  // r_src_rdy mirrors (state == STREAM), so a beat is simply a valid source word.
  assign w_beat = src_vld & r_src_rdy;
  assign w_last = (r_cnt == (r_len - WID_LEN'(1)));
  // Completion: last beat while streaming, or an empty batch served straight from IDLE.
  assign w_done = (r_state == S_STREAM) ? (w_beat & w_last)
                                        : ((r_pend != '0) & (r_len == '0));

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_act_nxt   = r_act_in;
    w_vld_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err_ovf;
    w_busy_nxt  = 1'b0;
    w_rdy_nxt   = 1'b0;

    if (cfg_en) begin
      w_len_nxt   = WID_LEN'(cfg_n_tn) * WID_LEN'(cfg_n_tp) * WID_LEN'(N_TILE);
      w_pend_nxt  = '0;
      w_cnt_nxt   = '0;
      w_err_nxt   = 1'b0;
      w_state_nxt = S_IDLE;
    end else begin
      if (act_in_req && !w_done) begin
        if (r_pend == WID_PEND'(MAX_PEND)) begin
          w_err_nxt = 1'b1;
        end else begin
          w_pend_nxt = r_pend + WID_PEND'(1);
        end
      end else if (!act_in_req && w_done) begin
        w_pend_nxt = r_pend - WID_PEND'(1);
      end

      w_done_nxt = w_done;

      case (r_state)
        S_IDLE: begin
          if ((r_pend != '0) && (r_len != '0)) begin
            w_state_nxt = S_STREAM;
            w_cnt_nxt   = '0;
          end
        end
        S_STREAM: begin
          if (w_beat) begin
            w_vld_nxt = 1'b1;
            w_act_nxt = src_data;
            if (w_last) begin
              // Back-to-back batches restart the count without leaving STREAM.
              w_cnt_nxt = '0;
              if (w_pend_nxt == '0) begin
                w_state_nxt = S_IDLE;
              end
            end else begin
              w_cnt_nxt = r_cnt + WID_LEN'(1);
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt == S_STREAM) | (w_pend_nxt != '0);
    w_rdy_nxt  = (w_state_nxt == S_STREAM);
  end

  // State and output registers.
  always_ff @(posedge clk_l) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pend       <= '0;
      r_cnt        <= '0;
      r_len        <= '0;
      r_act_in     <= '0;
      r_act_in_vld <= 1'b0;
      r_batch_done <= 1'b0;
      r_busy       <= 1'b0;
      r_err_ovf    <= 1'b0;
      r_src_rdy    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pend       <= w_pend_nxt;
      r_cnt        <= w_cnt_nxt;
      r_len        <= w_len_nxt;
      r_act_in     <= w_act_nxt;
      r_act_in_vld <= w_vld_nxt;
      r_batch_done <= w_done_nxt;
      r_busy       <= w_busy_nxt;
      r_err_ovf    <= w_err_nxt;
      r_src_rdy    <= w_rdy_nxt;
    end
  end

  assign src_rdy    = r_src_rdy;
  assign act_in     = r_act_in;
  assign act_in_vld = r_act_in_vld;
  assign batch_done = r_batch_done;
  assign busy       = r_busy;
  assign err_ovf    = r_err_ovf;

endmodule
